// File: rtl/or_gate.sv
// ---------------------------------------------------------------------------
// or_gate : registered bitwise-OR slice of the 16-bit ALU.
//
// On a clock edge with in_valid=1, this block registers four values:
//   - the bitwise OR a|b
//   - a one-bit "any bit set" summary
//   - a zero flag
//   - the population count of a|b
// Latency is one cycle and throughput is one operation per cycle.
// There is no backpressure.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   in_valid     in   1      operands a/b valid this cycle
//   a, b         in   WIDTH  operands
//   out_valid    out  1      registered outputs were updated on the last edge
//   result       out  WIDTH  registered a|b
//   gate_output  out  1      registered |(a|b)
//   zero         out  1      registered ~|(a|b)
//   ones_count   out  CNT_W  registered popcount(a|b)
// ---------------------------------------------------------------------------
module or_gate #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             gate_output,
  output logic             zero,
  output logic [CNT_W-1:0] ones_count
);

  // The popcount tree is padded up to a power of two.
  // Leaves beyond WIDTH are tied to zero.
  localparam int LEVELS = $clog2(WIDTH);
  localparam int PAD    = 1 << LEVELS;

  logic [WIDTH-1:0] w_or;
  logic [CNT_W-1:0] w_popcount;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_gate_output;
  logic             r_zero;
  logic [CNT_W-1:0] r_ones_count;

  assign w_or = a | b;

  // Balanced adder tree.
  // Each level has its own node array, so no net feeds back into itself.
  // A node never exceeds WIDTH, so CNT_W bits are enough at every level.
  genvar gl, gi;
  generate
    for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
      localparam int N = PAD >> gl;
      logic [CNT_W-1:0] w_node [N];
      for (gi = 0; gi < N; gi++) begin : g_node
        if (gl == 0) begin : g_leaf
          if (gi < WIDTH) begin : g_bit
            assign w_node[gi] = CNT_W'(w_or[gi]);
          end else begin : g_pad
            assign w_node[gi] = '0;
          end
        end else begin : g_add
          assign w_node[gi] = g_lvl[gl-1].w_node[2*gi] + g_lvl[gl-1].w_node[2*gi+1];
        end
      end
    end
  endgenerate

  assign w_popcount = g_lvl[LEVELS].w_node[0];

  // The payload registers load only when in_valid=1.
  // Garbage or X on a/b during idle cycles therefore never reaches state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_gate_output <= 1'b0;
      r_zero        <= 1'b0;
      r_ones_count  <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result      <= w_or;
        r_gate_output <= |w_or;
        r_zero        <= ~|w_or;
        r_ones_count  <= w_popcount;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign gate_output = r_gate_output;
  assign zero        = r_zero;
  assign ones_count  = r_ones_count;

endmodule

// File: tb/tb_or_gate.sv
// ---------------------------------------------------------------------------
// tb_or_gate : self-checking bench for or_gate.
//
// Each accepted operand pair pushes its expected outputs into a queue.
// The entry is popped and compared when out_valid is seen.
// On idle cycles the outputs are compared against the last captured value.
// ---------------------------------------------------------------------------
module tb_or_gate;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             gate_output;
    logic             zero;
    logic [CNT_W-1:0] ones_count;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             gate_output;
  logic             zero;
  logic [CNT_W-1:0] ones_count;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  or_gate #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .gate_output(gate_output),
    .zero(zero), .ones_count(ones_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".result"}, 32'(result), 32'(e.result));
    chk({tag, ".gate_output"}, 32'(gate_output), 32'(e.gate_output));
    chk({tag, ".zero"}, 32'(zero), 32'(e.zero));
    chk({tag, ".ones_count"}, 32'(ones_count), 32'(e.ones_count));
  endtask

  // Drives one cycle of stimulus and checks the outputs one cycle later.
  task automatic step(input string tag, input logic v,
                      input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    a = va;
    b = vb;
    if (v) begin
      e.result      = va | vb;
      e.gate_output = ((va | vb) != '0);
      e.zero        = ((va | vb) == '0);
      e.ones_count  = CNT_W'($countones(va | vb));
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".unexpected_valid"}, 32'(out_valid), 32'd0);
      end else begin
        last_exp = exp_q.pop_front();
      end
    end
    chk_outputs(tag, last_exp);
    $display("step %-10s v=%0b a=%h b=%h -> ov=%0b res=%h g=%0b z=%0b cnt=%0d",
             tag, v, va, vb, out_valid, result, gate_output, zero, ones_count);
  endtask

  initial begin
    last_exp = '{result: '0, gate_output: 1'b0, zero: 1'b0, ones_count: '0};

    // Reset without any clock edge having occurred.
    #2;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk_outputs("reset", last_exp);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("idle0", 1'b0, 16'h0000, 16'h0000);
    step("idle1", 1'b0, 16'h0000, 16'h0000);

    // Directed spec vectors, with their constants cross-checked too.
    step("t2", 1'b1, 16'h1082, 16'h1082);
    chk("t2.cnt_const", 32'(ones_count), 32'd3);
    step("t3", 1'b1, 16'h4648, 16'h1082);
    chk("t3.res_const", 32'(result), 32'h56CA);
    chk("t3.cnt_const", 32'(ones_count), 32'd8);
    step("t4zero", 1'b1, 16'h0000, 16'h0000);
    chk("t4.zero_const", 32'(zero), 32'd1);
    step("t4full", 1'b1, 16'hFFFF, 16'h0000);
    chk("t4.cnt_const", 32'(ones_count), 32'd16);
    step("t4single", 1'b1, 16'h0000, 16'h8000);

    // Hold: idle operands must not leak into the registers, including X.
    step("hold_cap", 1'b1, 16'h4648, 16'h1082);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 16'hFFFF, 16'hFFFF);
    chk("hold.res_const", 32'(result), 32'h56CA);
    step("hold_x", 1'b0, 'x, 'x);

    // Random back-to-back traffic with gaps.
    for (int i = 0; i < 24; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));

    // Reset asserted between edges, after a capture.
    step("pre_rst", 1'b1, 16'hA5A5, 16'h0F0F);
    rst = 1'b1;
    #1;
    last_exp = '{result: '0, gate_output: 1'b0, zero: 1'b0, ones_count: '0};
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk_outputs("midrst", last_exp);
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    @(posedge clk);
    #1;
    chk("rst_edge.out_valid", 32'(out_valid), 32'd0);
    chk_outputs("rst_edge", last_exp);
    $display("step %-10s rst=1 in_valid=1 -> ov=%0b res=%h", "rst_edge", out_valid, result);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    step("post_rst", 1'b0, 16'h0000, 16'h0000);
    step("recover", 1'b1, 16'h0300, 16'h0030);
    step("tail", 1'b0, 16'h0000, 16'h0000);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
